// File: rtl/avfs_pkg.sv
// -----------------------------------------------------------------------------
// avfs_pkg
// Shared definitions for the adaptive voltage/frequency scaling controller:
// register offsets, channel mode encoding and register reset values.
// -----------------------------------------------------------------------------
package avfs_pkg;

  // Channel mode field of CH_CFG. Encoding 2'b11 is also treated as hold.
  typedef enum logic [1:0] {
    MODE_AUTO   = 2'b00,
    MODE_MANUAL = 2'b01,
    MODE_HOLD   = 2'b10
  } mode_e;

  // Register offsets (byte addresses on the 8-bit register bus)
  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_WINDOW  = 8'h04;
  localparam logic [7:0] ADDR_THRESH  = 8'h08;
  localparam logic [7:0] ADDR_SETTLE  = 8'h0C;
  localparam logic [7:0] ADDR_CH_CFG  = 8'h10;  // + 4*channel
  localparam logic [7:0] ADDR_CH_STAT = 8'h40;  // + 4*channel, read-only

  // Register reset values
  localparam logic        RST_ENABLE = 1'b1;
  localparam int          RST_WINDOW = 64;
  localparam logic [15:0] RST_LO     = 16'd16;
  localparam logic [15:0] RST_HI     = 16'd48;
  localparam logic [7:0]  RST_SETTLE = 8'd2;

  // Shortest window the WINDOW register will accept
  localparam int MIN_WINDOW = 4;

endpackage

// File: rtl/avfs_channel.sv
// -----------------------------------------------------------------------------
// avfs_channel
// One activity/frequency channel: counts busy cycles over the shared window,
// decides level steps in auto mode, applies manual/hold/max overrides and
// tracks the post-change cooldown.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_enable      global enable; 0 forces level, counters and cooldown to 0
//   i_win_end     last cycle of the current window
//   i_clr         WINDOW register write: drop the partial count
//   i_activity    busy indication for this channel
//   i_mode        CH_CFG mode field
//   i_manual      manual level
//   i_max         maximum level
//   i_lo, i_hi    activity thresholds
//   i_settle      cooldown length in windows
//   o_level       current frequency level (registered)
//   o_chg         one-cycle pulse when o_level changes
//   o_last_cnt    activity count of the last completed window
// -----------------------------------------------------------------------------
module avfs_channel
  import avfs_pkg::*;
#(
  parameter int LVL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_win_end,
  input  logic             i_clr,
  input  logic             i_activity,
  input  logic [1:0]       i_mode,
  input  logic [LVL_W-1:0] i_manual,
  input  logic [LVL_W-1:0] i_max,
  input  logic [15:0]      i_lo,
  input  logic [15:0]      i_hi,
  input  logic [7:0]       i_settle,
  output logic [LVL_W-1:0] o_level,
  output logic             o_chg,
  output logic [15:0]      o_last_cnt
);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0]      r_cnt;
  logic [15:0]      r_last_cnt;
  logic [LVL_W-1:0] r_level;
  logic [7:0]       r_cool;
  logic             r_chg;

  logic [15:0]      w_cnt_final;
  logic [LVL_W-1:0] w_level_nxt;
  logic [7:0]       w_cool_nxt;

  // Count including the current cycle, so the window-end decision sees it
  assign w_cnt_final = i_activity ? sat_inc(r_cnt) : r_cnt;

  // Level priority: disable, max clamp (any mode), manual, auto step at window end
  always_comb begin
    w_level_nxt = r_level;
    if (!i_enable) begin
      w_level_nxt = '0;
    end else if (r_level > i_max) begin
      w_level_nxt = i_max;
    end else if (i_mode == MODE_MANUAL) begin
      w_level_nxt = (i_manual > i_max) ? i_max : i_manual;
    end else if (i_mode == MODE_AUTO && i_win_end && r_cool == 8'd0) begin
      // Increment test first so that hi<lo still favours stepping up
      if (w_cnt_final > i_hi && r_level < i_max) begin
        w_level_nxt = r_level + LVL_W'(1);
      end else if (w_cnt_final < i_lo && r_level != '0) begin
        w_level_nxt = r_level - LVL_W'(1);
      end
    end
  end

  always_comb begin
    w_cool_nxt = r_cool;
    if (!i_enable) begin
      w_cool_nxt = 8'd0;
    end else if (w_level_nxt != r_level) begin
      w_cool_nxt = i_settle;
    end else if (i_win_end && r_cool != 8'd0) begin
      w_cool_nxt = r_cool - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_last_cnt <= '0;
      r_level    <= '0;
      r_cool     <= '0;
      r_chg      <= 1'b0;
    end else begin
      if (!i_enable || i_clr || i_win_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_final;
      end
      if (i_win_end) begin
        r_last_cnt <= w_cnt_final;
      end
      r_level <= w_level_nxt;
      r_cool  <= w_cool_nxt;
      r_chg   <= (w_level_nxt != r_level);
    end
  end

  assign o_level    = r_level;
  assign o_chg      = r_chg;
  assign o_last_cnt = r_last_cnt;

endmodule

// File: rtl/avfs_mc_controller.sv
// -----------------------------------------------------------------------------
// avfs_mc_controller
// Multi-channel AVFS controller: register file, shared window counter and
// NUM_CH avfs_channel instances that pick a frequency level from activity.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   activity     per-channel busy indication
//   freq_sel     per-channel level, channel c at [c*LVL_W +: LVL_W]
//   freq_chg     per-channel one-cycle pulse on level change
//   apb_sel/we   register bus select / write enable (write on posedge)
//   apb_addr     register byte address
//   apb_wdata    write data
//   apb_rdata    combinational read data (0 when not reading or unmapped)
// -----------------------------------------------------------------------------
module avfs_mc_controller
  import avfs_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int LVL_W  = 4,
  parameter int WIN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       activity,
  output logic [NUM_CH*LVL_W-1:0] freq_sel,
  output logic [NUM_CH-1:0]       freq_chg,
  input  logic                    apb_sel,
  input  logic                    apb_we,
  input  logic [7:0]              apb_addr,
  input  logic [31:0]             apb_wdata,
  output logic [31:0]             apb_rdata
);

  logic             r_enable;
  logic [WIN_W-1:0] r_window;
  logic [WIN_W-1:0] r_win_cnt;
  logic [15:0]      r_lo;
  logic [15:0]      r_hi;
  logic [7:0]       r_settle;
  logic [1:0]       r_mode   [NUM_CH];
  logic [LVL_W-1:0] r_manual [NUM_CH];
  logic [LVL_W-1:0] r_max    [NUM_CH];

  logic             w_wr;
  logic             w_win_wr;
  logic             w_win_end;
  logic [WIN_W-1:0] w_win_wdata;
  logic [LVL_W-1:0] w_level    [NUM_CH];
  logic [15:0]      w_last_cnt [NUM_CH];

  assign w_wr        = apb_sel & apb_we;
  assign w_win_wr    = w_wr && (apb_addr == ADDR_WINDOW);
  assign w_win_wdata = (apb_wdata[WIN_W-1:0] < WIN_W'(MIN_WINDOW)) ?
                       WIN_W'(MIN_WINDOW) : apb_wdata[WIN_W-1:0];
  assign w_win_end   = r_enable && (r_win_cnt == r_window - WIN_W'(1));

  // Register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable <= RST_ENABLE;
      r_window <= WIN_W'(RST_WINDOW);
      r_lo     <= RST_LO;
      r_hi     <= RST_HI;
      r_settle <= RST_SETTLE;
      for (int c = 0; c < NUM_CH; c++) begin
        r_mode[c]   <= MODE_AUTO;
        r_manual[c] <= '0;
        r_max[c]    <= '1;
      end
    end else if (w_wr) begin
      case (apb_addr)
        ADDR_CTRL:   r_enable <= apb_wdata[0];
        ADDR_WINDOW: r_window <= w_win_wdata;
        ADDR_THRESH: begin
          r_lo <= apb_wdata[15:0];
          r_hi <= apb_wdata[31:16];
        end
        ADDR_SETTLE: r_settle <= apb_wdata[7:0];
        default: ;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
        if (apb_addr == ADDR_CH_CFG + 8'(4 * c)) begin
          r_mode[c]   <= apb_wdata[1:0];
          r_manual[c] <= apb_wdata[8 +: LVL_W];
          r_max[c]    <= apb_wdata[16 +: LVL_W];
        end
      end
    end
  end

  // Shared window counter; held at 0 while disabled so re-enable starts fresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_cnt <= '0;
    end else if (!r_enable || w_win_wr || w_win_end) begin
      r_win_cnt <= '0;
    end else begin
      r_win_cnt <= r_win_cnt + WIN_W'(1);
    end
  end

  always_comb begin
    apb_rdata = '0;
    if (apb_sel && !apb_we) begin
      case (apb_addr)
        ADDR_CTRL:   apb_rdata = {31'd0, r_enable};
        ADDR_WINDOW: apb_rdata = 32'(r_window);
        ADDR_THRESH: apb_rdata = {r_hi, r_lo};
        ADDR_SETTLE: apb_rdata = {24'd0, r_settle};
        default: ;
      endcase
      for (int c = 0; c < NUM_CH; c++) begin
        if (apb_addr == ADDR_CH_CFG + 8'(4 * c)) begin
          apb_rdata = 32'(r_mode[c]) | (32'(r_manual[c]) << 8) |
                      (32'(r_max[c]) << 16);
        end
        if (apb_addr == ADDR_CH_STAT + 8'(4 * c)) begin
          apb_rdata = {w_last_cnt[c], 16'(w_level[c])};
        end
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    avfs_channel #(
      .LVL_W(LVL_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_enable  (r_enable),
      .i_win_end (w_win_end),
      .i_clr     (w_win_wr),
      .i_activity(activity[c]),
      .i_mode    (r_mode[c]),
      .i_manual  (r_manual[c]),
      .i_max     (r_max[c]),
      .i_lo      (r_lo),
      .i_hi      (r_hi),
      .i_settle  (r_settle),
      .o_level   (w_level[c]),
      .o_chg     (freq_chg[c]),
      .o_last_cnt(w_last_cnt[c])
    );
    assign freq_sel[c*LVL_W +: LVL_W] = w_level[c];
  end

endmodule

// File: tb/tb_avfs_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_avfs_mc_controller
// Self-checking bench for avfs_mc_controller (NUM_CH=2, LVL_W=4, WIN_W=16).
// Expected values are queued when stimulus is applied and compared when the
// DUT result is due. Observed word = {22'b0, freq_chg[1:0], freq_sel[7:0]}.
// -----------------------------------------------------------------------------
module tb_avfs_mc_controller;
  import avfs_pkg::*;

  localparam int NUM_CH = 2;
  localparam int LVL_W  = 4;
  localparam int WIN_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       activity;
  logic [NUM_CH*LVL_W-1:0] freq_sel;
  logic [NUM_CH-1:0]       freq_chg;
  logic                    apb_sel;
  logic                    apb_we;
  logic [7:0]              apb_addr;
  logic [31:0]             apb_wdata;
  logic [31:0]             apb_rdata;

  avfs_mc_controller #(
    .NUM_CH(NUM_CH),
    .LVL_W (LVL_W),
    .WIN_W (WIN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .activity (activity),
    .freq_sel (freq_sel),
    .freq_chg (freq_chg),
    .apb_sel  (apb_sel),
    .apb_we   (apb_we),
    .apb_addr (apb_addr),
    .apb_wdata(apb_wdata),
    .apb_rdata(apb_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    int n_act;
    int lvl;
    bit chg;
  } win_vec_t;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  win_vec_t wtab[10];
  reg_vec_t regtab[18];
  int       cd_lvl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t it;
    it.name = name;
    it.exp  = exp;
    sbq.push_back(it);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    sb_t it;
    if (sbq.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL sb_empty: got %h expected nothing pending", act);
    end else begin
      it = sbq.pop_front();
      check(it.name, act, it.exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {22'd0, freq_chg, freq_sel};
  endfunction

  // Expected observation with ch1 at level 0 and no ch1 pulse
  function automatic logic [31:0] eo(input int l0, input bit c0);
    return {22'd0, 1'b0, c0, 4'h0, 4'(l0)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
    apb_sel   = 1'b1;
    apb_we    = 1'b1;
    apb_addr  = addr;
    apb_wdata = data;
    @(posedge clk);
    #1;
    apb_sel = 1'b0;
    apb_we  = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data);
    apb_sel  = 1'b1;
    apb_we   = 1'b0;
    apb_addr = addr;
    #1;
    data    = apb_rdata;
    apb_sel = 1'b0;
  endtask

  task automatic stat_chk(input string name, input logic [31:0] exp);
    logic [31:0] d;
    sb_push(name, exp);
    apb_read(ADDR_CH_STAT, d);
    sb_pop(d);
  endtask

  // One 8-cycle window with n_act active cycles on channel 0
  task automatic run_window(input int n_act);
    for (int i = 0; i < 8; i++) begin
      activity[0] = (i < n_act);
      tick(1);
      if (i == 0) check("chg_pulse_width", 32'(freq_chg[0]), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;

    // Ramp-down, then boundary windows, starting from level 3 (lo=2, hi=6)
    wtab[0] = '{0, 2, 1};
    wtab[1] = '{0, 1, 1};
    wtab[2] = '{0, 0, 1};
    wtab[3] = '{0, 0, 0};
    wtab[4] = '{8, 1, 1};
    wtab[5] = '{8, 2, 1};
    wtab[6] = '{6, 2, 0};
    wtab[7] = '{2, 2, 0};
    wtab[8] = '{7, 3, 1};
    wtab[9] = '{1, 2, 1};

    // Cooldown with SETTLE=2: steps at windows 1, 4, 7
    cd_lvl = '{3, 3, 3, 4, 4, 4, 5, 5, 5};

    regtab[0]  = '{1'b0, 8'h00, 32'h0, 32'h0000_0001};
    regtab[1]  = '{1'b0, 8'h04, 32'h0, 32'h0000_0040};
    regtab[2]  = '{1'b0, 8'h08, 32'h0, 32'h0030_0010};
    regtab[3]  = '{1'b0, 8'h0C, 32'h0, 32'h0000_0002};
    regtab[4]  = '{1'b0, 8'h10, 32'h0, 32'h000F_0000};
    regtab[5]  = '{1'b0, 8'h14, 32'h0, 32'h000F_0000};
    regtab[6]  = '{1'b0, 8'h40, 32'h0, 32'h0000_0000};
    regtab[7]  = '{1'b0, 8'h44, 32'h0, 32'h0000_0000};
    regtab[8]  = '{1'b0, 8'h18, 32'h0, 32'h0000_0000};
    regtab[9]  = '{1'b0, 8'h48, 32'h0, 32'h0000_0000};
    regtab[10] = '{1'b0, 8'hFC, 32'h0, 32'h0000_0000};
    regtab[11] = '{1'b1, 8'h04, 32'h0000_0002, 32'h0000_0004};
    regtab[12] = '{1'b1, 8'h04, 32'h0000_0000, 32'h0000_0004};
    regtab[13] = '{1'b1, 8'h04, 32'h0000_0005, 32'h0000_0005};
    regtab[14] = '{1'b1, 8'h08, 32'h1234_5678, 32'h1234_5678};
    regtab[15] = '{1'b1, 8'h0C, 32'hFFFF_FF07, 32'h0000_0007};
    regtab[16] = '{1'b1, 8'h14, 32'hFFFF_FFFF, 32'h000F_0F03};
    regtab[17] = '{1'b1, 8'h04, 32'h0001_0010, 32'h0000_0010};

    rst       = 1'b1;
    activity  = '0;
    apb_sel   = 1'b0;
    apb_we    = 1'b0;
    apb_addr  = '0;
    apb_wdata = '0;
    tick(3);
    check("rst_obs", obs(), 32'd0);
    rst = 1'b0;
    tick(1);
    check("post_rst_obs", obs(), 32'd0);

    // Ramp-up: ch0 fully busy, one step per 8-cycle window, saturating at 15
    apb_write(ADDR_THRESH, 32'h0006_0002);
    apb_write(ADDR_SETTLE, 32'd0);
    activity[0] = 1'b1;
    apb_write(ADDR_WINDOW, 32'd8);
    for (int w = 1; w <= 16; w++) begin
      sb_push($sformatf("ramp_up_w%0d", w), eo((w < 15) ? w : 15, (w <= 15)));
      run_window(8);
      sb_pop(obs());
    end
    stat_chk("stat_ramp_up", 32'h0008_000F);

    // Max written below the current level clamps in auto mode
    apb_write(ADDR_CH_CFG, 32'h0003_0000);
    check("clamp_pre", obs(), eo(15, 0));
    tick(1);
    check("clamp_max", obs(), eo(3, 1));
    activity[0] = 1'b0;
    apb_write(ADDR_CH_CFG, 32'h000F_0000);
    apb_write(ADDR_WINDOW, 32'd8);

    for (int i = 0; i < 10; i++) begin
      sb_push($sformatf("win_tab%0d", i), eo(wtab[i].lvl, wtab[i].chg));
      run_window(wtab[i].n_act);
      sb_pop(obs());
      stat_chk($sformatf("stat_tab%0d", i), {16'(wtab[i].n_act), 16'(wtab[i].lvl)});
    end

    // Cooldown
    apb_write(ADDR_SETTLE, 32'd2);
    activity[0] = 1'b1;
    apb_write(ADDR_WINDOW, 32'd8);
    for (int w = 0; w < 9; w++) begin
      sb_push($sformatf("cooldown_w%0d", w + 1), eo(cd_lvl[w], (w % 3) == 0));
      run_window(8);
      sb_pop(obs());
    end

    // Reset mid-window
    tick(3);
    rst = 1'b1;
    #1;
    check("rst_mid_obs", obs(), 32'd0);
    stat_chk("rst_mid_stat", 32'd0);
    activity = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_mid_release", obs(), 32'd0);

    // Register reset values, unmapped addresses, write clamps
    for (int i = 0; i < 18; i++) begin
      sb_push($sformatf("reg%0d_a%02h", i, regtab[i].addr), regtab[i].exp);
      if (regtab[i].wr) apb_write(regtab[i].addr, regtab[i].wdata);
      apb_read(regtab[i].addr, d);
      sb_pop(d);
    end

    tick(1);
    apb_sel  = 1'b0;
    apb_we   = 1'b0;
    apb_addr = ADDR_CTRL;
    #1;
    check("rdata_no_sel", apb_rdata, 32'd0);
    apb_sel = 1'b1;
    apb_we  = 1'b1;
    #1;
    check("rdata_during_wr", apb_rdata, 32'd0);
    apb_sel = 1'b0;
    apb_we  = 1'b0;
    tick(1);

    // Manual mode and max limit
    apb_write(ADDR_CH_CFG, 32'h0005_0901);
    check("manual_pre", obs(), eo(0, 0));
    tick(1);
    check("manual_level", obs(), eo(5, 1));
    apb_write(ADDR_CH_CFG, 32'h0003_0901);
    tick(1);
    check("manual_max", obs(), eo(3, 1));

    // Hold: level frozen, counting continues
    apb_write(ADDR_CH_CFG, 32'h000F_0002);
    check("hold_keep", obs(), eo(3, 0));
    activity[0] = 1'b1;
    apb_write(ADDR_WINDOW, 32'd8);
    sb_push("hold_window", eo(3, 0));
    run_window(8);
    sb_pop(obs());
    stat_chk("hold_stat", 32'h0008_0003);

    // Disable forces level 0
    apb_write(ADDR_CTRL, 32'd0);
    tick(1);
    check("disable_level", obs(), eo(0, 1));
    tick(10);
    check("disabled_hold", obs(), eo(0, 0));

    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
